// File: rtl/adc_avg_bcd.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_bcd
// Description : Averages 2**N_LOG2 ADC samples per window on the selected
//               channel, then converts the average (in mV) to four packed BCD
//               digits with a sequential double-dabble converter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous active-high reset
//   chan         in   3   currently selected ADC channel
//   result       in  12   ADC conversion code, 1 LSB = 1 mV
//   sample_valid in   1   strobe, result valid this cycle
//   avg          out 12   most recent window average
//   avg_chan     out  3   channel that avg / mv_bcd belongs to
//   mv_bcd       out 16   average as packed BCD, [15:12] = thousands
//   out_valid    out  1   strobe, mv_bcd / avg_chan newly updated
//   busy         out  1   BCD converter running
//   overrun      out  1   strobe, a completed window was discarded
// ============================================================================
module adc_avg_bcd #(
    parameter int N_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  chan,
    input  logic [11:0] result,
    input  logic        sample_valid,
    output logic [11:0] avg,
    output logic [2:0]  avg_chan,
    output logic [15:0] mv_bcd,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int c_ACC_W = 12 + N_LOG2;
    localparam int c_CNT_W = (N_LOG2 > 0) ? N_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << N_LOG2) - 1);
    localparam logic [3:0] c_LAST_ITER = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_clr;
    logic [2:0]           r_chan_q;
    logic [2:0]           r_win_chan;
    logic [11:0]          r_avg;
    logic [2:0]           r_avg_chan;
    logic [15:0]          r_mv_bcd;
    logic                 r_out_valid;
    logic                 r_overrun;
    logic [27:0]          r_sr;
    logic [3:0]           r_iter;

    logic                 w_chan_chg;
    logic                 w_accept;
    logic                 w_win_done;
    logic                 w_overrun_nxt;
    logic [c_ACC_W-1:0]   w_acc_base;
    logic [c_CNT_W-1:0]   w_cnt_base;
    logic [27:0]          w_sr_adj;
    logic [11:0]          w_win_avg;

    // A completed window keeps its full sum in r_acc for one more cycle so the
    // LOAD state can read it; r_clr makes the following cycle start from zero.
    assign w_chan_chg = (chan != r_chan_q);
    assign w_accept   = sample_valid && !w_chan_chg;
    assign w_acc_base = r_clr ? '0 : r_acc;
    assign w_cnt_base = r_clr ? '0 : r_cnt;
    assign w_win_done = w_accept && (w_cnt_base == c_CNT_LAST);
    assign w_win_avg  = 12'(r_acc >> N_LOG2);

    // Double-dabble correction: add 3 to every BCD digit >= 5 before shifting.
    always_comb begin
        w_sr_adj = r_sr;
        for (int d = 0; d < 4; d++) begin
            if (r_sr[12 + 4*d +: 4] >= 4'd5) begin
                w_sr_adj[12 + 4*d +: 4] = r_sr[12 + 4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_nxt = 1'b0;
        case (r_state)
            S_IDLE:  if (w_win_done) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_iter == c_LAST_ITER) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_win_done && (r_state != S_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_clr       <= 1'b0;
            r_chan_q    <= chan;
            r_win_chan  <= '0;
            r_avg       <= '0;
            r_avg_chan  <= '0;
            r_mv_bcd    <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_sr        <= '0;
            r_iter      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_chan_q    <= chan;
            r_overrun   <= w_overrun_nxt;
            r_out_valid <= 1'b0;
            r_clr       <= w_win_done;

            if (w_chan_chg) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_base + c_ACC_W'(result);
                r_cnt <= w_win_done ? '0 : w_cnt_base + 1'b1;
            end else begin
                r_acc <= w_acc_base;
                r_cnt <= w_cnt_base;
            end

            case (r_state)
                S_LOAD: begin
                    r_avg      <= w_win_avg;
                    r_sr       <= {16'd0, w_win_avg};
                    r_iter     <= '0;
                    r_win_chan <= r_chan_q;
                end
                S_SHIFT: begin
                    r_sr   <= {w_sr_adj[26:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                end
                S_DONE: begin
                    r_mv_bcd    <= r_sr[27:12];
                    r_avg_chan  <= r_win_chan;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign avg       = r_avg;
    assign avg_chan  = r_avg_chan;
    assign mv_bcd    = r_mv_bcd;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_avg_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_avg_bcd
// Description : Self-checking bench for adc_avg_bcd. Two instances (N_LOG2=4
//               and N_LOG2=0) share one stimulus stream; a cycle-level
//               behavioural model predicts every output of both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_avg_bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  chan = 3'd2;
    logic [11:0] result = '0;
    logic        sample_valid = 1'b0;

    logic [11:0] avg4, avg0;
    logic [2:0]  avgch4, avgch0;
    logic [15:0] bcd4, bcd0;
    logic        ov4, ov0, busy4, busy0, ovr4, ovr0;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;

    always #5 clk = ~clk;

    adc_avg_bcd #(.N_LOG2(4)) u_dut4 (
        .clk(clk), .reset(reset), .chan(chan), .result(result),
        .sample_valid(sample_valid), .avg(avg4), .avg_chan(avgch4),
        .mv_bcd(bcd4), .out_valid(ov4), .busy(busy4), .overrun(ovr4)
    );

    adc_avg_bcd #(.N_LOG2(0)) u_dut0 (
        .clk(clk), .reset(reset), .chan(chan), .result(result),
        .sample_valid(sample_valid), .avg(avg0), .avg_chan(avgch0),
        .mv_bcd(bcd0), .out_valid(ov0), .busy(busy0), .overrun(ovr0)
    );

    // Reference model state, index 0 -> N_LOG2=4 instance, 1 -> N_LOG2=0.
    int m_sum[2], m_cnt[2], m_start[2], m_pend[2];
    int m_avg[2], m_winch[2], m_chq[2], m_bcd[2], m_avgch[2];
    bit m_ov[2], m_ovr[2];

    function automatic int to_bcd(input int a);
        return (a / 1000) * 4096 + ((a / 100) % 10) * 256 + ((a / 10) % 10) * 16 + (a % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", tag, edge_no, got, exp);
        end
    endtask

    task automatic model(input int i, input bit rst, input int ch, input int res, input bit sv);
        int  nlog;
        bit  busy_before;
        nlog = (i == 0) ? 4 : 0;
        if (rst) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_start[i] = -1; m_pend[i] = 0;
            m_avg[i] = 0; m_winch[i] = 0; m_bcd[i] = 0; m_avgch[i] = 0;
            m_ov[i] = 0; m_ovr[i] = 0; m_chq[i] = ch;
            return;
        end
        m_ov[i]  = 0;
        m_ovr[i] = 0;
        busy_before = (m_start[i] >= 0) && (edge_no > m_start[i]);
        if (m_start[i] >= 0 && edge_no == m_start[i] + 1) begin
            m_avg[i]   = m_pend[i] >> nlog;
            m_winch[i] = m_chq[i];
        end
        if (m_start[i] >= 0 && edge_no == m_start[i] + 14) begin
            m_bcd[i]   = to_bcd(m_avg[i]);
            m_avgch[i] = m_winch[i];
            m_ov[i]    = 1;
            m_start[i] = -1;
        end
        if (ch != m_chq[i]) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
        end else if (sv) begin
            m_sum[i] += res;
            m_cnt[i]++;
            if (m_cnt[i] == (1 << nlog)) begin
                if (busy_before) begin
                    m_ovr[i] = 1;
                end else begin
                    m_start[i] = edge_no;
                    m_pend[i]  = m_sum[i];
                end
                m_sum[i] = 0;
                m_cnt[i] = 0;
            end
        end
        m_chq[i] = ch;
    endtask

    task automatic check_all();
        chk("n4_out_valid", 32'(ov4),    32'(m_ov[0]));
        chk("n4_overrun",   32'(ovr4),   32'(m_ovr[0]));
        chk("n4_busy",      32'(busy4),  32'(m_start[0] >= 0));
        chk("n4_avg",       32'(avg4),   m_avg[0]);
        chk("n4_mv_bcd",    32'(bcd4),   m_bcd[0]);
        chk("n4_avg_chan",  32'(avgch4), m_avgch[0]);
        chk("n0_out_valid", 32'(ov0),    32'(m_ov[1]));
        chk("n0_overrun",   32'(ovr0),   32'(m_ovr[1]));
        chk("n0_busy",      32'(busy0),  32'(m_start[1] >= 0));
        chk("n0_avg",       32'(avg0),   m_avg[1]);
        chk("n0_mv_bcd",    32'(bcd0),   m_bcd[1]);
        chk("n0_avg_chan",  32'(avgch0), m_avgch[1]);
    endtask

    task automatic step(input bit rst, input int ch, input int res, input bit sv);
        @(negedge clk);
        reset        = rst;
        chan         = 3'(ch);
        result       = 12'(res);
        sample_valid = sv;
        @(posedge clk);
        edge_no++;
        model(0, rst, ch, res, sv);
        model(1, rst, ch, res, sv);
        #1;
        check_all();
    endtask

    task automatic idle(input int ch, input int n);
        for (int k = 0; k < n; k++) step(0, ch, 0, 0);
    endtask

    task automatic burst(input int ch, input int res, input int n);
        for (int k = 0; k < n; k++) step(0, ch, res, 1);
    endtask

    initial begin
        int ov_pulses;
        int cur_ch;

        // Reset with a sample_valid present; it must be ignored.
        step(1, 2, 4000, 1);
        step(1, 2, 0, 0);
        chk("reset_avg", 32'(avg4), 32'd0);
        chk("reset_busy", 32'(busy4), 32'd0);

        // Steady input; out_valid exactly 14 cycles after the 16th sample.
        burst(2, 1234, 16);
        for (int k = 1; k < 14; k++) begin
            step(0, 2, 0, 0);
            chk("steady_no_early_valid", 32'(ov4), 32'd0);
        end
        step(0, 2, 0, 0);
        chk("steady_valid_at_14", 32'(ov4), 32'd1);
        chk("steady_bcd", 32'(bcd4), 32'h1234);
        chk("steady_avg", 32'(avg4), 32'd1234);
        chk("steady_chan", 32'(avgch4), 32'd2);
        idle(2, 4);

        // Truncation: 8*0 + 8*4095 = 32760 -> 2047.
        for (int k = 0; k < 16; k++) step(0, 2, (k % 2) ? 4095 : 0, 1);
        idle(2, 16);
        chk("trunc_avg", 32'(avg4), 32'd2047);
        chk("trunc_bcd", 32'(bcd4), 32'h2047);

        // Full scale and zero.
        burst(2, 4095, 16);
        idle(2, 16);
        chk("full_bcd", 32'(bcd4), 32'h4095);
        burst(2, 0, 16);
        idle(2, 16);
        chk("zero_bcd", 32'(bcd4), 32'h0000);

        // Channel change mid-window discards the partial window.
        burst(2, 500, 5);
        step(0, 3, 3000, 1);
        burst(3, 100, 16);
        idle(3, 16);
        chk("chg_avg", 32'(avg4), 32'd100);
        chk("chg_chan", 32'(avgch4), 32'd3);
        chk("chg_bcd", 32'(bcd4), 32'h0100);

        // Overrun on the N_LOG2=0 instance.
        ov_pulses = 0;
        step(0, 3, 7, 1);
        idle(3, 2);
        step(0, 3, 9, 1);
        for (int k = 0; k < 20; k++) begin
            if (ovr0) ov_pulses++;
            step(0, 3, 0, 0);
        end
        chk("ovr_pulses", 32'(ov_pulses), 32'd1);
        chk("ovr_avg", 32'(avg0), 32'd7);
        chk("ovr_bcd", 32'(bcd0), 32'h0007);

        // Reset during SHIFT aborts; next window converts correctly.
        burst(3, 1234, 16);
        idle(3, 5);
        step(1, 3, 0, 0);
        chk("rst_shift_bcd", 32'(bcd4), 32'd0);
        chk("rst_shift_busy", 32'(busy4), 32'd0);
        idle(3, 16);
        burst(3, 321, 16);
        idle(3, 16);
        chk("rst_next_bcd", 32'(bcd4), 32'h0321);

        // Randomised traffic.
        cur_ch = 3;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) cur_ch = $urandom_range(0, 7);
            step(($urandom_range(0, 299) == 0), cur_ch, $urandom_range(0, 4095),
                 ($urandom_range(0, 1) == 1));
        end
        idle(cur_ch, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_avg_bcd.md
ADC_AVG_BCD -- requirements
Module: adc_avg_bcd

Interface
REQ-001 Parameter: N_LOG2, default 4, log2 of samples averaged per window (legal 0..6).
REQ-002 clk  input  1  system clock (CLOCK_50 at top level).
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 chan  input  3  ADC channel currently selected (from enc2chan).
REQ-005 result  input  12  ADC conversion code (from adcinterface); 1 LSB = 1 mV, 0..4095.
REQ-006 sample_valid  input  1  one-cycle strobe; result is valid in this cycle.
REQ-007 avg  output  12  most recent window average code.
REQ-008 avg_chan  output  3  channel that avg belongs to.
REQ-009 mv_bcd  output  16  avg as 4 packed BCD digits; [15:12] is thousands, [3:0] is units.
REQ-010 out_valid  output  1  one-cycle strobe; mv_bcd and avg_chan are newly updated.
REQ-011 busy  output  1  BCD converter is running.
REQ-012 overrun  output  1  one-cycle strobe; a completed window was discarded.

Function
REQ-013 Accumulator: width 12+N_LOG2 bits; adds result on each accepted sample_valid; no overflow is possible.
REQ-014 Sample counter: counts 0..2^N_LOG2-1 and wraps to 0 on the Nth accepted sample (window complete).
REQ-015 Window complete at edge k, converter idle:
  - at edge k+1: avg = sum >> N_LOG2 (truncating), and chan_q is captured for the window.
  - the accumulator and counter clear at edge k+1, so the next sample starts a fresh window.
REQ-016 Channel tracking:
  - chan_q is registered every cycle.
  - when chan != chan_q, the accumulator and counter clear on that edge.
  - any sample_valid in that cycle is discarded.
  - avg, avg_chan and mv_bcd hold their values.
REQ-017 Converter FSM states:
  - IDLE -> LOAD on window complete.
  - LOAD -> SHIFT (loads avg into the shift register, BCD register = 0).
  - SHIFT runs 12 iterations, one per cycle: first add 3 to each BCD digit >= 5, then shift left 1.
  - SHIFT -> DONE after the 12th iteration.
  - DONE -> IDLE.
REQ-018 Conversion timing:
  - Nth sample at edge k gives the LOAD action at k+1, SHIFT on edges k+2..k+13, DONE at k+14.
  - DONE writes mv_bcd and avg_chan and pulses out_valid high for exactly the cycle after edge k+14.
REQ-019 busy is high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-020 Window complete while busy:
  - the window's average is discarded; avg and the converter are unaffected.
  - overrun pulses for one cycle.
  - the accumulator and counter still clear.
REQ-021 Accumulation continues during conversion; sample_valid is never back-pressured.
REQ-022 Output range: mv_bcd is always in 0x0000..0x4095, and every nibble is <= 9.
REQ-023 N_LOG2=0: every accepted sample is a complete window.

Reset
REQ-024 On reset:
  - avg, avg_chan, mv_bcd, out_valid, busy and overrun = 0.
  - accumulator and counter = 0; FSM = IDLE; chan_q = chan.
REQ-025 Reset asserted mid-accumulation or mid-conversion aborts it on that edge; no out_valid follows.
REQ-026 sample_valid during a reset cycle is ignored.

Verification
REQ-027 Bench scenarios:
  - Steady input: chan=2, 16 samples of result=1234 → avg=1234, mv_bcd=0x1234, avg_chan=2, out_valid 14 cycles after the 16th sample.
  - Truncation: 16 samples alternating 0/4095 → sum 32760, avg=2047, mv_bcd=0x2047.
  - Full scale: 16 samples of 4095 → mv_bcd=0x4095; samples of 0 → mv_bcd=0x0000.
  - Channel change: 5 samples, then chan 2→3, then 16 samples of 100 → out_valid only after those 16, avg=100, avg_chan=3.
  - Overrun: N_LOG2=0, samples 7 and 9 applied 3 cycles apart → first gives 0x0007 and one overrun pulse, avg stays 7.
  - Reset during SHIFT → outputs all 0 next cycle, no out_valid; the next full window converts correctly.
